// File: rtl/pkt_stream_arb.sv
// Packet-atomic round-robin arbiter: muxes NUM_SRC Avalon-ST sources onto one
// registered output stream, holding each grant until the packet's EOP beat.

module pkt_stream_arb_lane (
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  input  logic clr,
  output logic flag
);
  // A violation seen in the same cycle as a clear takes precedence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  flag <= 1'b0;
    else if (set)  flag <= 1'b1;
    else if (clr)  flag <= 1'b0;
  end
endmodule

module pkt_stream_arb #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 8,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_SRC-1:0]         in_valid,
  input  logic [NUM_SRC-1:0]         in_sop,
  input  logic [NUM_SRC-1:0]         in_eop,
  input  logic [NUM_SRC*DATA_W-1:0]  in_data,
  input  logic [NUM_SRC*EMPTY_W-1:0] in_empty,
  input  logic [NUM_SRC-1:0]         in_error,
  output logic [NUM_SRC-1:0]         in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [DATA_W-1:0]          out_data,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic                       out_error,
  output logic [SRC_W-1:0]           out_src,
  output logic [NUM_SRC-1:0]         frame_err,
  input  logic                       frame_err_clr
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [SRC_W:0] NSRC = (SRC_W+1)'(NUM_SRC);

  state_t             state;
  logic [SRC_W-1:0]   grant, last, winner, sel;
  logic               pipe_ready, any_req, fwd_acc, mid_sop;
  logic [NUM_SRC-1:0] req, flush;

  logic [DATA_W-1:0]  data_a  [NUM_SRC];
  logic [EMPTY_W-1:0] empty_a [NUM_SRC];

  assign pipe_ready = out_ready | ~out_valid;
  assign req        = in_valid & in_sop;
  assign flush      = (state == IDLE) ? (in_valid & ~in_sop) : '0;

  // Rotating scan starting just after the last served source.
  always_comb begin
    logic [SRC_W:0] cand;
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, last} + (SRC_W+1)'(k);
      if (cand >= NSRC) cand = cand - NSRC;
      if (!any_req && req[cand[SRC_W-1:0]]) begin
        any_req = 1'b1;
        winner  = cand[SRC_W-1:0];
      end
    end
  end

  assign sel     = (state == IDLE) ? winner : grant;
  assign fwd_acc = pipe_ready & ((state == IDLE) ? any_req : in_valid[grant]);
  assign mid_sop = (state == BUSY) & fwd_acc & in_sop[grant];

  always_comb begin
    in_ready = '0;
    if (reset_n) begin
      if (state == IDLE) begin
        in_ready = flush;
        if (any_req && pipe_ready) in_ready[winner] = 1'b1;
      end else begin
        in_ready[grant] = pipe_ready;
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    assign data_a[i]  = in_data[i*DATA_W +: DATA_W];
    assign empty_a[i] = in_empty[i*EMPTY_W +: EMPTY_W];

    pkt_stream_arb_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .set     (flush[i] | (mid_sop & (grant == SRC_W'(i)))),
      .clr     (frame_err_clr),
      .flag    (frame_err[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= SRC_W'(NUM_SRC-1);
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_empty <= '0;
      out_error <= 1'b0;
      out_src   <= '0;
    end else if (fwd_acc) begin
      out_valid <= 1'b1;
      out_sop   <= in_sop[sel];
      out_eop   <= in_eop[sel];
      out_data  <= data_a[sel];
      out_empty <= empty_a[sel];
      out_error <= in_error[sel] | mid_sop;
      out_src   <= sel;
      if (state == IDLE) begin
        if (in_eop[sel]) begin
          last <= winner;
        end else begin
          grant <= winner;
          state <= BUSY;
        end
      end else if (in_eop[sel]) begin
        last  <= grant;
        state <= IDLE;
      end
    end else if (pipe_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pkt_stream_arb.sv
// Randomized and directed bench for pkt_stream_arb, checked every cycle against
// a packet-level reference model (owner/round-robin pointer/output register).

module tb_pkt_stream_arb;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int EW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    in_valid, in_sop, in_eop, in_error, in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*EW-1:0] in_empty;
  logic            out_ready, out_valid, out_sop, out_eop, out_error;
  logic [DW-1:0]   out_data;
  logic [EW-1:0]   out_empty;
  logic [SW-1:0]   out_src;
  logic [N-1:0]    frame_err;
  logic            frame_err_clr;

  pkt_stream_arb #(.NUM_SRC(N), .DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .in_empty(in_empty), .in_error(in_error),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_empty(out_empty), .out_error(out_error), .out_src(out_src),
    .frame_err(frame_err), .frame_err_clr(frame_err_clr)
  );

  always #5 clk = ~clk;

  typedef struct { bit sop, eop, err; logic [DW-1:0] data; logic [EW-1:0] empty; } beat_t;
  typedef struct { int src; bit sop, eop, err; logic [DW-1:0] data; logic [EW-1:0] empty; int cyc; } log_t;

  beat_t sq [N][$];
  bit    pres [N];
  log_t  lg [$];

  int checks = 0, errors = 0, cyc = 0, seqn = 0;
  int rdy_mode = 1, present_pct = 100, hold_low = 0;
  bit clr_drv = 0;

  // reference model state
  int owner, rr_last, msrc;
  bit mv, msop, meop, merr;
  logic [DW-1:0] mdata;
  logic [EW-1:0] mempty;
  logic [N-1:0]  mfe;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    owner = -1; rr_last = N-1; mv = 0; msop = 0; meop = 0; merr = 0;
    mdata = '0; mempty = '0; msrc = 0; mfe = '0;
  endtask

  task automatic add_pkt(int s, int len, bit orphan, int viol, bit rnd, logic [EW-1:0] elast);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.sop   = (!orphan && b == 0) || (b == viol);
      bt.eop   = (b == len-1);
      bt.err   = rnd ? ($urandom_range(9) == 0) : 1'b0;
      bt.empty = (b == len-1) ? (rnd ? EW'($urandom_range(7)) : elast) : '0;
      bt.data  = {8'(s), 24'(seqn), 32'($urandom)};
      seqn++;
      sq[s].push_back(bt);
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy, flushv;
    int fwd, cand;
    bit pr, mid;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && sq[i].size() > 0 && $urandom_range(99) < present_pct) pres[i] = 1;
      in_valid[i] = pres[i];
      if (pres[i]) begin
        in_sop[i] = sq[i][0].sop; in_eop[i] = sq[i][0].eop; in_error[i] = sq[i][0].err;
        in_data[i*DW +: DW] = sq[i][0].data; in_empty[i*EW +: EW] = sq[i][0].empty;
      end else begin
        in_sop[i] = 1'($urandom); in_eop[i] = 1'($urandom); in_error[i] = 1'($urandom);
        in_data[i*DW +: DW] = {$urandom, $urandom}; in_empty[i*EW +: EW] = 8'($urandom);
      end
    end
    if (hold_low > 0) begin out_ready = 0; hold_low--; end
    else out_ready = rdy_mode ? 1'b1 : ($urandom_range(99) < 75);
    frame_err_clr = clr_drv;
    #1;
    pr = out_ready || !mv;
    exp_rdy = '0; flushv = '0; fwd = -1; cand = -1;
    if (owner < 0) begin
      for (int i = 0; i < N; i++) flushv[i] = in_valid[i] && !in_sop[i];
      exp_rdy = flushv;
      for (int k = 1; k <= N; k++) begin
        int j = (rr_last + k) % N;
        if (cand < 0 && in_valid[j] && in_sop[j]) cand = j;
      end
      if (cand >= 0 && pr) begin exp_rdy[cand] = 1; fwd = cand; end
    end else begin
      if (pr) exp_rdy[owner] = 1;
      if (pr && in_valid[owner]) fwd = owner;
    end
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, mv);
    chk("frame_err", frame_err, mfe);
    if (mv) begin
      chk("out_sop", out_sop, msop);
      chk("out_eop", out_eop, meop);
      chk("out_error", out_error, merr);
      chk("out_data", out_data, mdata);
      chk("out_empty", out_empty, mempty);
      chk("out_src", out_src, 64'(msrc));
    end
    if (out_valid && out_ready)
      lg.push_back('{int'(out_src), out_sop, out_eop, out_error, out_data, out_empty, cyc});
    if (clr_drv) mfe = '0;
    mfe |= flushv;
    if (fwd >= 0) begin
      mid = (owner >= 0) && in_sop[fwd];
      mv = 1; msop = in_sop[fwd]; meop = in_eop[fwd]; merr = in_error[fwd] | mid;
      mdata = in_data[fwd*DW +: DW]; mempty = in_empty[fwd*EW +: EW]; msrc = fwd;
      if (mid) mfe[owner] = 1;
      if (owner < 0) begin
        if (in_eop[fwd]) rr_last = fwd; else owner = fwd;
      end else if (in_eop[fwd]) begin
        rr_last = owner; owner = -1;
      end
    end else if (pr) mv = 0;
    for (int i = 0; i < N; i++)
      if (in_valid[i] && exp_rdy[i]) begin void'(sq[i].pop_front()); pres[i] = 0; end
    cyc++;
  endtask

  function automatic bit busy_q();
    for (int i = 0; i < N; i++) if (sq[i].size() > 0) return 1;
    return mv;
  endfunction

  task automatic run_drain(int max);
    int n = 0;
    while (busy_q() && n < max) begin step(); n++; end
    checks++;
    if (n >= max) begin errors++; $display("FAIL drain_timeout act=%0d exp=<%0d", n, max); end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin sq[i].delete(); pres[i] = 0; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_d [4];
    int f, cnt;
    reset_n = 0; in_valid = '1; in_sop = '1; in_eop = '0; in_error = '0;
    in_data = '0; in_empty = '0; out_ready = 1; frame_err_clr = 0;
    clear_src(); model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk); in_valid = '0; reset_n = 1;

    // all sources, two 2-beat packets each: strict 0,1,2,3 rotation, no bubbles
    for (int s = 0; s < N; s++) begin add_pkt(s, 2, 0, -1, 0, 0); add_pkt(s, 2, 0, -1, 0, 0); end
    lg.delete(); run_drain(100);
    chk("rr_count", lg.size(), 16);
    for (int k = 0; k < lg.size() && k < 16; k++) chk("rr_src", lg[k].src, (k/2) % 4);
    if (lg.size() >= 16) chk("rr_no_bubble", lg[15].cyc - lg[0].cyc, 15);

    // single 3-beat packet from source 0
    add_pkt(0, 3, 0, -1, 0, 8'h05);
    lg.delete(); run_drain(50);
    chk("single_count", lg.size(), 3);
    if (lg.size() == 3) begin
      chk("single_sop", {lg[0].sop, lg[1].sop, lg[2].sop}, 3'b100);
      chk("single_eop", {lg[0].eop, lg[1].eop, lg[2].eop}, 3'b001);
      chk("single_src", lg[0].src + lg[1].src + lg[2].src, 0);
      chk("single_empty", lg[2].empty, 8'h05);
    end

    // backpressure mid-packet
    add_pkt(1, 4, 0, -1, 0, 0);
    for (int k = 0; k < 4; k++) exp_d[k] = sq[1][k].data;
    lg.delete(); step(); step(); hold_low = 3; run_drain(50);
    chk("bp_count", lg.size(), 4);
    for (int k = 0; k < lg.size() && k < 4; k++) chk("bp_data", lg[k].data, exp_d[k]);

    // orphan beat in IDLE, then clear
    add_pkt(2, 1, 1, -1, 0, 0);
    run_drain(20); step();
    chk("orphan_fe", frame_err, 4'b0100);
    clr_drv = 1; step(); clr_drv = 0; step();
    chk("clr_fe", frame_err, 4'b0000);

    // SOP mid-packet on source 1, with source 2 contending
    add_pkt(1, 4, 0, 1, 0, 0); add_pkt(2, 2, 0, -1, 0, 0);
    lg.delete(); run_drain(50); step();
    f = -1;
    foreach (lg[i]) if (f < 0 && lg[i].src == 1) f = i;
    cnt = 0;
    if (f >= 0) for (int k = f; k < f+4 && k < lg.size(); k++) if (lg[k].src == 1) cnt++;
    chk("midsop_contig", cnt, 4);
    chk("midsop_err", (f >= 0 && f+1 < lg.size()) ? lg[f+1].err : 1'b0, 1);
    chk("midsop_fe", frame_err[1], 1);

    // randomized traffic
    rdy_mode = 0; present_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        int s = $urandom_range(N-1);
        int r = $urandom_range(19);
        if (sq[s].size() < 6) add_pkt(s, $urandom_range(1, 5), r == 0, (r == 1) ? 1 : -1, 1, 0);
      end
      clr_drv = ($urandom_range(49) == 0);
      step();
    end
    clr_drv = 0; run_drain(500);

    // reset in the middle of a 4-beat packet
    rdy_mode = 1; present_pct = 100;
    add_pkt(0, 4, 0, -1, 0, 0); add_pkt(3, 2, 0, -1, 0, 0);
    begin
      int n = 0;
      while (sq[0].size() > 2 && n < 30) begin step(); n++; end
    end
    reset_n = 0; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    clear_src(); model_reset(); in_valid = '0;
    @(negedge clk); @(negedge clk); reset_n = 1;
    add_pkt(3, 2, 0, -1, 0, 0); add_pkt(0, 2, 0, -1, 0, 0);
    lg.delete(); run_drain(50);
    chk("midrst_first_src", lg.size() > 0 ? lg[0].src : -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
